regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 31-entry integer register file (x0 hard-wired zero) between two writeback sources: ALU and load unit (MEM).
- Keeps a per-register pending-write scoreboard so issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's r_write / data_write / enable_write inputs directly through a one-stage registered output.

---
 rtl/regfile_write_arbiter_if.sv | 58 +++++
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Module : regfile_write_arbiter_if
// Brief  : Writeback request, issue scoreboard and register-file write bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            issue_valid;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [4:0]      issue_rd;
  logic            issue_hazard;

  logic [4:0]      rf_r_write;
  logic [XLEN-1:0] rf_data_write;
  logic            rf_enable_write;
  logic [31:0]     commit_count;
  logic            err_unexpected;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_hazard,
    output rf_r_write, rf_data_write, rf_enable_write,
    output commit_count, err_unexpected
  );

  // Pipeline / environment side
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_hazard,
    input  rf_r_write, rf_data_write, rf_enable_write,
    input  commit_count, err_unexpected
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Brief  : Two-source writeback arbiter for the integer register file with a
//          per-register pending-write scoreboard and registered write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int XLEN      = 32,
  parameter bit RR_ENABLE = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_MEM = 1'b1;

  logic [0:0]      last_grant_q,      last_grant_d;
  logic            rf_enable_write_q, rf_enable_write_d;
  logic [4:0]      rf_r_write_q,      rf_r_write_d;
  logic [XLEN-1:0] rf_data_write_q,   rf_data_write_d;
  logic [31:0]     pending_q,         pending_d;
  logic [31:0]     commit_count_q,    commit_count_d;
  logic            err_unexpected_q,  err_unexpected_d;

  logic            conflict_pick_mem;
  logic            alu_grant;
  logic            mem_grant;
  logic            any_grant;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            hazard;
  logic            issue_claims;

  // Policy applied only when both sources request in the same cycle.
  generate
    if (RR_ENABLE) begin : g_rr_arb
      assign conflict_pick_mem = (last_grant_q == GRANT_ALU);
    end else begin : g_fixed_arb
      assign conflict_pick_mem = 1'b1;
    end
  endgenerate

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (bus.alu_valid && bus.mem_valid) begin
      mem_grant = conflict_pick_mem;
      alu_grant = !conflict_pick_mem;
    end else begin
      alu_grant = bus.alu_valid;
      mem_grant = bus.mem_valid;
    end
  end

  assign any_grant = alu_grant || mem_grant;
  assign sel_rd    = mem_grant ? bus.mem_rd   : bus.alu_rd;
  assign sel_data  = mem_grant ? bus.mem_data : bus.alu_data;

  // No bypass: a register committing this cycle still reads as pending.
  always_comb begin
    hazard = 1'b0;
    if ((bus.issue_rs1 != 5'd0) && pending_q[bus.issue_rs1]) hazard = 1'b1;
    if ((bus.issue_rs2 != 5'd0) && pending_q[bus.issue_rs2]) hazard = 1'b1;
    if ((bus.issue_rd  != 5'd0) && pending_q[bus.issue_rd])  hazard = 1'b1;
  end

  assign issue_claims = bus.issue_valid && !hazard && (bus.issue_rd != 5'd0);

  always_comb begin
    last_grant_d = last_grant_q;
    if (mem_grant) begin
      last_grant_d = GRANT_MEM;
    end else if (alu_grant) begin
      last_grant_d = GRANT_ALU;
    end
  end

  // x0 writes occupy the slot but never raise the write enable.
  always_comb begin
    rf_enable_write_d = any_grant && (sel_rd != 5'd0);
    rf_r_write_d      = rf_r_write_q;
    rf_data_write_d   = rf_data_write_q;
    if (any_grant) begin
      rf_r_write_d    = sel_rd;
      rf_data_write_d = sel_data;
    end
  end

  // Clear precedes set so a same-cycle collision leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (rf_enable_write_q) begin
      pending_d[rf_r_write_q] = 1'b0;
    end
    if (issue_claims) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    commit_count_d   = commit_count_q;
    err_unexpected_d = err_unexpected_q;
    if (rf_enable_write_q) begin
      commit_count_d = commit_count_q + 32'd1;
      if (!pending_q[rf_r_write_q]) begin
        err_unexpected_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q      <= GRANT_ALU;
      rf_enable_write_q <= 1'b0;
      rf_r_write_q      <= 5'd0;
      rf_data_write_q   <= '0;
      pending_q         <= '0;
      commit_count_q    <= 32'd0;
      err_unexpected_q  <= 1'b0;
    end else begin
      last_grant_q      <= last_grant_d;
      rf_enable_write_q <= rf_enable_write_d;
      rf_r_write_q      <= rf_r_write_d;
      rf_data_write_q   <= rf_data_write_d;
      pending_q         <= pending_d;
      commit_count_q    <= commit_count_d;
      err_unexpected_q  <= err_unexpected_d;
    end
  end

  assign bus.alu_ready       = alu_grant;
  assign bus.mem_ready       = mem_grant;
  assign bus.issue_hazard    = bus.issue_valid && hazard;
  assign bus.rf_enable_write = rf_enable_write_q;
  assign bus.rf_r_write      = rf_r_write_q;
  assign bus.rf_data_write   = rf_data_write_q;
  assign bus.commit_count    = commit_count_q;
  assign bus.err_unexpected  = err_unexpected_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module : tb_regfile_write_arbiter
// Brief  : Directed self-checking bench for regfile_write_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [XLEN-1:0] rf_model [32];

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.XLEN(XLEN)) bus ();
  regfile_write_arbiter_if #(.XLEN(XLEN)) bus_fp ();

  // Fixed-priority instance sees exactly the same requests.
  assign bus_fp.alu_valid   = bus.alu_valid;
  assign bus_fp.alu_rd      = bus.alu_rd;
  assign bus_fp.alu_data    = bus.alu_data;
  assign bus_fp.mem_valid   = bus.mem_valid;
  assign bus_fp.mem_rd      = bus.mem_rd;
  assign bus_fp.mem_data    = bus.mem_data;
  assign bus_fp.issue_valid = bus.issue_valid;
  assign bus_fp.issue_rs1   = bus.issue_rs1;
  assign bus_fp.issue_rs2   = bus.issue_rs2;
  assign bus_fp.issue_rd    = bus.issue_rd;

  regfile_write_arbiter #(.XLEN(XLEN), .RR_ENABLE(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_write_arbiter #(.XLEN(XLEN), .RR_ENABLE(1'b0)) u_dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  // Register file behind the write port.
  always @(posedge clk) begin
    if (bus.rf_enable_write) rf_model[bus.rf_r_write] <= bus.rf_data_write;
  end

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = 5'd0;
    bus.mem_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rs1   = 5'd0;
    bus.issue_rs2   = 5'd0;
    bus.issue_rd    = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = 32'h1111_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.rf_enable_write !== 1'b0) begin
        bad++; $display("FAIL reset_enable cyc%0d: got %0b want 0", i, bus.rf_enable_write);
      end
      total++;
      if (bus.commit_count !== 32'd0) begin
        bad++; $display("FAIL reset_count cyc%0d: got %0d want 0", i, bus.commit_count);
      end
    end
    total++;
    if (bus.err_unexpected !== 1'b0 || bus.rf_r_write !== 5'd0 || bus.rf_data_write !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: err=%0b addr=%0d data=%h want 0/0/0",
                      bus.err_unexpected, bus.rf_r_write, bus.rf_data_write);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.rf_enable_write !== 1'b0) begin
      bad++; $display("FAIL reset_release_enable: got %0b want 0", bus.rf_enable_write);
    end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    total++;
    if (bus.rf_enable_write !== 1'b1 || bus.rf_r_write !== 5'd1 || bus.rf_data_write !== 32'h1111_0001) begin
      bad++; $display("FAIL reset_first_grant: en=%0b addr=%0d data=%h want 1/1/11110001",
                      bus.rf_enable_write, bus.rf_r_write, bus.rf_data_write);
    end
    do_reset();
  endtask

  task automatic test_scoreboard();
    do_reset();
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b0) begin
      bad++; $display("FAIL sb_issue_rd5: hazard=%0b want 0", bus.issue_hazard);
    end
    @(negedge clk);
    bus.issue_rd  = 5'd0;
    bus.issue_rs1 = 5'd5;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b1) begin
      bad++; $display("FAIL sb_raw_rs1: hazard=%0b want 1", bus.issue_hazard);
    end
    bus.issue_rs1 = 5'd0;
    bus.issue_rs2 = 5'd5;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b1) begin
      bad++; $display("FAIL sb_raw_rs2: hazard=%0b want 1", bus.issue_hazard);
    end
    bus.issue_rs2 = 5'd6;
    bus.issue_rd  = 5'd5;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b1) begin
      bad++; $display("FAIL sb_waw_rd: hazard=%0b want 1", bus.issue_hazard);
    end
    bus.issue_valid = 1'b0;
    bus.issue_rs1   = 5'd5;
    bus.issue_rs2   = 5'd0;
    bus.issue_rd    = 5'd0;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b0) begin
      bad++; $display("FAIL sb_no_valid: hazard=%0b want 0", bus.issue_hazard);
    end
    @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    #1;
    total++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      bad++; $display("FAIL sb_alu_grant: alu_ready=%0b mem_ready=%0b want 1/0", bus.alu_ready, bus.mem_ready);
    end
    @(negedge clk);
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    #1;
    total++;
    if (bus.rf_enable_write !== 1'b1 || bus.rf_r_write !== 5'd5 || bus.rf_data_write !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sb_commit: en=%0b addr=%0d data=%h want 1/5/deadbeef",
                      bus.rf_enable_write, bus.rf_r_write, bus.rf_data_write);
    end
    total++;
    if (bus.issue_hazard !== 1'b1) begin
      bad++; $display("FAIL sb_no_bypass: hazard=%0b want 1", bus.issue_hazard);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.issue_hazard !== 1'b0) begin
      bad++; $display("FAIL sb_cleared: hazard=%0b want 0", bus.issue_hazard);
    end
    total++;
    if (rf_model[5] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sb_rf_x5: got %h want deadbeef", rf_model[5]);
    end
    total++;
    if (bus.commit_count !== 32'd1 || bus.err_unexpected !== 1'b0 || bus.rf_enable_write !== 1'b0) begin
      bad++; $display("FAIL sb_after: count=%0d err=%0b en=%0b want 1/0/0",
                      bus.commit_count, bus.err_unexpected, bus.rf_enable_write);
    end
    bus.issue_valid = 1'b0;
    bus.issue_rs1   = 5'd0;
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_mem;
    exp_mem = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_data  = 32'h0000_0303;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'd4;
      bus.mem_data  = 32'h0000_0404;
      #1;
      total++;
      if (bus.mem_ready !== exp_mem[i] || bus.alu_ready !== !exp_mem[i]) begin
        bad++; $display("FAIL rr_grant%0d: mem_ready=%0b alu_ready=%0b want %0b/%0b",
                        i, bus.mem_ready, bus.alu_ready, exp_mem[i], !exp_mem[i]);
      end
      total++;
      if (bus_fp.mem_ready !== 1'b1 || bus_fp.alu_ready !== 1'b0) begin
        bad++; $display("FAIL fp_grant%0d: mem_ready=%0b alu_ready=%0b want 1/0",
                        i, bus_fp.mem_ready, bus_fp.alu_ready);
      end
      if (i > 0) begin
        total++;
        if (bus.rf_enable_write !== 1'b1 || bus.rf_r_write !== (exp_mem[i-1] ? 5'd4 : 5'd3)) begin
          bad++; $display("FAIL rr_write%0d: en=%0b addr=%0d want 1/%0d",
                          i, bus.rf_enable_write, bus.rf_r_write, exp_mem[i-1] ? 4 : 3);
        end
      end
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    total++;
    if (bus.rf_r_write !== 5'd3 || bus_fp.rf_r_write !== 5'd4) begin
      bad++; $display("FAIL arb_last_write: rr=%0d fp=%0d want 3/4", bus.rf_r_write, bus_fp.rf_r_write);
    end
    total++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
      bad++; $display("FAIL arb_single_alu: alu_ready=%0b mem_ready=%0b want 1/0", bus.alu_ready, bus.mem_ready);
    end
    @(negedge clk);
    bus.alu_valid = 1'b0;
  endtask

  task automatic test_x0_write();
    do_reset();
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'h0000_ABCD;
    #1;
    total++;
    if (bus.mem_ready !== 1'b1) begin
      bad++; $display("FAIL x0_ready: got %0b want 1", bus.mem_ready);
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    total++;
    if (bus.rf_enable_write !== 1'b0) begin
      bad++; $display("FAIL x0_enable: got %0b want 0", bus.rf_enable_write);
    end
    @(negedge clk);
    total++;
    if (bus.commit_count !== 32'd0 || bus.err_unexpected !== 1'b0) begin
      bad++; $display("FAIL x0_count_err: count=%0d err=%0b want 0/0", bus.commit_count, bus.err_unexpected);
    end
  endtask

  task automatic test_unexpected();
    @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h0000_7777;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    total++;
    if (bus.rf_enable_write !== 1'b1 || bus.rf_r_write !== 5'd7) begin
      bad++; $display("FAIL unexp_commit: en=%0b addr=%0d want 1/7", bus.rf_enable_write, bus.rf_r_write);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.err_unexpected !== 1'b1 || bus.commit_count !== 32'd1) begin
      bad++; $display("FAIL unexp_sticky: err=%0b count=%0d want 1/1", bus.err_unexpected, bus.commit_count);
    end
    total++;
    if (rf_model[7] !== 32'h0000_7777) begin
      bad++; $display("FAIL unexp_rf_x7: got %h want 00007777", rf_model[7]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.err_unexpected !== 1'b0) begin
      bad++; $display("FAIL unexp_cleared: err=%0b want 0", bus.err_unexpected);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd9;
    bus.alu_data    = 32'h0000_9999;
    #1;
    total++;
    if (bus.alu_ready !== 1'b1) begin
      bad++; $display("FAIL mid_grant: alu_ready=%0b want 1", bus.alu_ready);
    end
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    total++;
    if (bus.rf_enable_write !== 1'b1 || bus.rf_r_write !== 5'd9) begin
      bad++; $display("FAIL mid_staged: en=%0b addr=%0d want 1/9", bus.rf_enable_write, bus.rf_r_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rf_enable_write !== 1'b0) begin
      bad++; $display("FAIL mid_discard: en=%0b want 0", bus.rf_enable_write);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rs1   = 5'd9;
    #1;
    total++;
    if (bus.issue_hazard !== 1'b0) begin
      bad++; $display("FAIL mid_pending: hazard=%0b want 0", bus.issue_hazard);
    end
    total++;
    if (rf_model[9] !== 32'd0 || bus.commit_count !== 32'd0) begin
      bad++; $display("FAIL mid_no_write: x9=%h count=%0d want 0/0", rf_model[9], bus.commit_count);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    test_reset();
    test_scoreboard();
    test_arbitration();
    test_x0_write();
    test_unexpected();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
